// File: rtl/flow_control_pkg.sv
// flow_control_pkg: shared constants and select-field helpers for flow_control_nport_credit
package flow_control_pkg;
  localparam int DEF_NPORT = 4;
  localparam int DEF_CREDIT_DEPTH = 4;
  localparam int DEF_STALLW = 16;
  function automatic int sel_idle(input int nport);
    return nport;
  endfunction
  function automatic int sel_field(input logic [31:0] bus, input int selw, input int idx);
    return int'((bus >> (idx * selw)) & ((32'd1 << selw) - 32'd1));
  endfunction
endpackage

// File: rtl/credit_counter.sv
// credit_counter: free-slot counter for one downstream FIFO, saturating at CREDIT_DEPTH
module credit_counter
  import flow_control_pkg::*;
#(
  parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
  parameter int CW = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          nonzero,
  output logic          ovf_pulse
);
  localparam logic [CW-1:0] MAX = CW'(CREDIT_DEPTH);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    ovf_pulse = inc && !dec && cnt_q == MAX;
    cnt_d = (dec && !inc && cnt_q != '0) ? cnt_q - CW'(1)
          : (inc && !dec && cnt_q != MAX) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= MAX;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign nonzero = |cnt_q;
endmodule

// File: rtl/flow_control_nport_credit.sv
// flow_control_nport_credit: N-port credit-based send/enable generation; optional stall counters under FLOW_CTRL_STALL_CNT_EN
module flow_control_nport_credit
  import flow_control_pkg::*;
#(
  parameter int NPORT = DEF_NPORT,
  parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
  parameter int SELW = $clog2(NPORT + 1),
  parameter int CW = $clog2(CREDIT_DEPTH + 1),
  parameter int STALLW = DEF_STALLW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORT*SELW-1:0]   out_sw,
  input  logic [NPORT-1:0]        valid,
  input  logic [NPORT-1:0]        empty,
  input  logic [NPORT-1:0]        credit_ret,
  output logic [NPORT-1:0]        en,
  output logic [NPORT-1:0]        en_fifo,
  output logic [NPORT-1:0]        send,
  output logic [NPORT*CW-1:0]     credit_cnt,
  output logic                    err_cfg,
  output logic                    err_ovf,
  output logic [NPORT*STALLW-1:0] stall_cnt
);
  localparam int IDLE = sel_idle(NPORT);
  logic [SELW-1:0] sel [NPORT];
  logic [NPORT-1:0] nonzero, ovf, taken;
  logic dup, err_cfg_q, err_cfg_d, err_ovf_q, err_ovf_d;
  for (genvar g = 0; g < NPORT; g++) begin : g_port
    assign sel[g] = SELW'(sel_field(32'(out_sw), SELW, g));
    credit_counter #(.CREDIT_DEPTH(CREDIT_DEPTH), .CW(CW)) u_cc (
      .clk(clk), .rst(rst), .dec(send[g]), .inc(credit_ret[g]),
      .cnt(credit_cnt[g*CW +: CW]), .nonzero(nonzero[g]), .ovf_pulse(ovf[g])
    );
  end
  // first output claiming a valid input wins it; later claimants are flagged as duplicates
  always_comb begin
    send = '0;
    en = ~valid;
    taken = '0;
    dup = 1'b0;
    for (int o = 0; o < NPORT; o++)
      for (int i = 0; i < NPORT; i++)
        if (sel[o] != SELW'(IDLE) && sel[o] == SELW'(i) && valid[i]) begin
          dup = dup | taken[i];
          send[o] = !taken[i] && nonzero[o];
          en[i] = en[i] | (!taken[i] && nonzero[o]);
          taken[i] = 1'b1;
        end
    err_cfg_d = err_cfg_q | dup;
    err_ovf_d = err_ovf_q | (|ovf);
  end
  assign en_fifo = en & ~empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_cfg_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      err_cfg_q <= err_cfg_d;
      err_ovf_q <= err_ovf_d;
    end
  assign err_cfg = err_cfg_q;
  assign err_ovf = err_ovf_q;
`ifdef FLOW_CTRL_STALL_CNT_EN
  logic [NPORT*STALLW-1:0] stall_q, stall_d;
  always_comb begin
    stall_d = stall_q;
    for (int i = 0; i < NPORT; i++)
      stall_d[i*STALLW +: STALLW] = (valid[i] && !en[i] && stall_q[i*STALLW +: STALLW] != '1)
        ? stall_q[i*STALLW +: STALLW] + STALLW'(1) : stall_q[i*STALLW +: STALLW];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_q <= '0;
    else stall_q <= stall_d;
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_flow_control_nport_credit.sv
// tb_flow_control_nport_credit: directed + random stimulus with a queue scoreboard against a credit model
module tb_flow_control_nport_credit;
  localparam int N = 4;
  localparam int D = 4;
  localparam int SELW = 3;
  localparam int CW = 3;
  localparam int STALLW = 16;
  typedef struct {
    logic [N-1:0] en, en_fifo, send;
    logic [N*CW-1:0] cc;
    logic ec, eo;
    logic [N*STALLW-1:0] st;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*SELW-1:0] out_sw = '0;
  logic [N-1:0] valid = '0, empty = '0, credit_ret = '0;
  logic [N-1:0] en, en_fifo, send;
  logic [N*CW-1:0] credit_cnt;
  logic err_cfg, err_ovf;
  logic [N*STALLW-1:0] stall_cnt;
  int checks = 0, errors = 0;
  exp_t q[$];
  int cred [N];
  int stall [N];
  bit ecfg, eovf;

  flow_control_nport_credit #(.NPORT(N), .CREDIT_DEPTH(D), .SELW(SELW), .CW(CW), .STALLW(STALLW)) dut (
    .clk(clk), .rst(rst), .out_sw(out_sw), .valid(valid), .empty(empty), .credit_ret(credit_ret),
    .en(en), .en_fifo(en_fifo), .send(send), .credit_cnt(credit_cnt),
    .err_cfg(err_cfg), .err_ovf(err_ovf), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, b, $time);
    end
  endtask

  function automatic logic [N*SELW-1:0] mk_sw(input int a0, input int a1, input int a2, input int a3);
    return {SELW'(a3), SELW'(a2), SELW'(a1), SELW'(a0)};
  endfunction

  // reference model: credits are free slots, each output takes its input if unclaimed and credit remains
  task automatic step(input logic [N*SELW-1:0] sw, input logic [N-1:0] v, input logic [N-1:0] e,
                      input logic [N-1:0] cr, input logic r);
    exp_t x;
    logic [N-1:0] snd, en_e, claimed;
    bit dupl;
    int s;
    @(posedge clk);
    #1;
    rst = r; out_sw = sw; valid = v; empty = e; credit_ret = cr;
    if (r) begin
      for (int o = 0; o < N; o++) begin cred[o] = D; stall[o] = 0; end
      ecfg = 0; eovf = 0;
    end
    snd = '0; claimed = '0; dupl = 0; en_e = ~v;
    for (int o = 0; o < N; o++) begin
      s = int'(sw[o*SELW +: SELW]);
      if (s < N) if (v[s]) begin
        if (claimed[s]) dupl = 1;
        else if (cred[o] > 0) begin snd[o] = 1'b1; en_e[s] = 1'b1; end
        claimed[s] = 1'b1;
      end
    end
    x.en = en_e; x.en_fifo = en_e & ~e; x.send = snd; x.ec = ecfg; x.eo = eovf;
    for (int o = 0; o < N; o++) begin
      x.cc[o*CW +: CW] = CW'(cred[o]);
      x.st[o*STALLW +: STALLW] = STALLW'(stall[o]);
    end
    q.push_back(x);
    if (!r) begin
      for (int o = 0; o < N; o++)
        if (cr[o] && !snd[o]) begin
          if (cred[o] == D) eovf = 1; else cred[o]++;
        end else if (snd[o] && !cr[o]) cred[o]--;
      if (dupl) ecfg = 1;
`ifdef FLOW_CTRL_STALL_CNT_EN
      for (int i = 0; i < N; i++)
        if (v[i] && !en_e[i] && stall[i] < 65535) stall[i]++;
`endif
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("en", 64'(en), 64'(x.en));
        chk("en_fifo", 64'(en_fifo), 64'(x.en_fifo));
        chk("send", 64'(send), 64'(x.send));
        chk("credit_cnt", 64'(credit_cnt), 64'(x.cc));
        chk("err_cfg", 64'(err_cfg), 64'(x.ec));
        chk("err_ovf", 64'(err_ovf), 64'(x.eo));
        chk("stall_cnt", 64'(stall_cnt), 64'(x.st));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [N*SELW-1:0] idle, sw;
    logic [N-1:0] cr;
    idle = mk_sw(4, 4, 4, 4);
    repeat (2) step(idle, '0, '0, '0, 1'b1);
    repeat (2) step(idle, '0, 4'b1010, '0, 1'b0);
    sw = mk_sw(4, 4, 1, 4);
    for (int k = 0; k < 6; k++) step(sw, 4'b0010, 4'b0000, '0, 1'b0);
    step(idle, '0, '0, '0, 1'b1);
    for (int k = 0; k < 8; k++) step(sw, 4'b0010, 4'b0010, (k == 4 || k == 5) ? 4'b0100 : 4'b0000, 1'b0);
    step(idle, '0, '0, '0, 1'b1);
    for (int k = 0; k < 3; k++) step(mk_sw(3, 4, 4, 3), 4'b1000, '0, '0, 1'b0);
    step(idle, '0, '0, 4'b0010, 1'b0);
    step(idle, '0, '0, '0, 1'b0);
    for (int k = 0; k < 2; k++) step(mk_sw(0, 1, 2, 3), 4'b1111, '0, '0, 1'b0);
    step(mk_sw(0, 1, 2, 3), 4'b1111, '0, '0, 1'b1);
    step(idle, '0, '0, '0, 1'b0);
    for (int k = 0; k < 14; k++) step(mk_sw(0, 4, 4, 4), 4'b0001, '0, '0, 1'b0);
    step(idle, '0, '0, '0, 1'b1);
    for (int k = 0; k < 400; k++) begin
      for (int o = 0; o < N; o++) begin
        sw[o*SELW +: SELW] = SELW'($urandom_range(0, 7));
        cr[o] = (cred[o] < D && $urandom_range(0, 2) == 0) || $urandom_range(0, 63) == 0;
      end
      step(sw, N'($urandom), N'($urandom), cr, $urandom_range(0, 99) == 0);
    end
    step(idle, '0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flow_control_nport_credit.md
Name: flow_control_nport_credit

Overview:
- Parametrised successor to the fixed 4-port router flow-control block.
- Generalised to NPORT inputs/outputs with an index-encoded crossbar select per output.
- Replaces downstream "full" levels with per-output credit counters, tracking free slots in the next hop's input FIFO.
- Sits between the switch allocator (supplies out_sw) and the input FIFOs/crossbar; produces pipeline advance enables, FIFO pops and per-output send strobes.

Parameters:
- NPORT, 4, number of input ports and output ports (2..8).
- CREDIT_DEPTH, 4, downstream FIFO depth; credit counter reset/max value (1..15).
- SELW, $clog2(NPORT+1), width of one select field.
- CW, $clog2(CREDIT_DEPTH+1), width of one credit counter.
- STALLW, 16, width of optional per-input stall counters.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- out_sw  in  NPORT*SELW  field o = input index driving output o; value NPORT = idle.
- valid  in  NPORT  input stage i holds a valid flit.
- empty  in  NPORT  input FIFO i empty.
- credit_ret  in  NPORT  one-cycle pulse; downstream of output o freed one slot.
- en  out  NPORT  input stage i may advance.
- en_fifo  out  NPORT  pop input FIFO i.
- send  out  NPORT  output o transfers a flit this cycle.
- credit_cnt  out  NPORT*CW  current credits per output (registered).
- err_cfg  out  1  sticky: two outputs selected the same valid input.
- err_ovf  out  1  sticky: credit returned while counter already at CREDIT_DEPTH.
- stall_cnt  out  NPORT*STALLW  per-input stall counters (optional feature).

Behaviour:
- Reset (async assert, sync deassert by the clock edge):
  - credit_cnt[o] = CREDIT_DEPTH.
  - err_cfg = 0, err_ovf = 0, stall_cnt = 0.
  - Combinational outputs follow from the reset state.
- Send decision (combinational from registered credits):
  - send[o] = (sel_o != NPORT) & (sel_o < NPORT) & valid[sel_o] & (credit_cnt[o] != 0).
  - sel_o > NPORT (illegal code) is treated as idle.
- Duplicate select: if several outputs select the same valid input, only the lowest-index output may assert send; err_cfg sets on the next edge and holds until rst.
- Enable:
  - en[i] = !valid[i] | (some o with send[o] and sel_o == i).
  - With valid[i] = 0, en[i] = 1 (bubble collapse).
- FIFO pop: en_fifo[i] = en[i] & !empty[i].
- Zero combinational path from credit_ret to en/send; credit returns become usable the cycle after the pulse.
- Credit counter per output, next = cnt - send[o] + credit_ret[o]:
  - send and credit_ret in the same cycle: count unchanged.
  - credit_ret at CREDIT_DEPTH without send: count saturates at CREDIT_DEPTH and err_ovf sets.
  - send at 0: impossible by construction (send is gated by cnt != 0).
- Latency:
  - en/send are 0-cycle (same cycle as valid/out_sw).
  - Counter update takes 1 cycle.
  - Round trip = downstream return delay + 1.
- Reset mid-transfer: counters return to full immediately. In-flight returns arriving after reset saturate and set err_ovf; the system must reset downstream FIFOs together with this block.

Optional Feature:
- Macro: FLOW_CTRL_STALL_CNT_EN.
- Defined:
  - Per input, a STALLW-bit counter increments each cycle valid[i] & !en[i].
  - It saturates at all-ones and holds when the condition drops.
  - It clears only on rst.
- Undefined: stall_cnt tied to 0, no flops inferred; port list unchanged.

Decomposition:
- Package flow_control_pkg:
  - SEL_IDLE function/constant (returns NPORT).
  - Select-field extraction helper.
  - Default CREDIT_DEPTH and STALLW constants.
- Sub-module credit_counter (parameter CREDIT_DEPTH): inputs dec/inc, outputs cnt/nonzero/ovf_pulse; instantiated NPORT times by generate.
- Enable/send logic and stall counters stay in the top.

Test Plan:
- Reset with all sel idle, valid=0 -> en=all 1s, send=0, each credit_cnt=4, err flags 0.
- NPORT=4, out_sw[2]=1, valid[1]=1 held 6 cycles, no returns -> send[2]=1 for 4 cycles, credit_cnt[2] 4→3→2→1→0, then en[1]=0, send[2]=0.
- Same as previous with credit_ret[2] pulsed on the cycle credit hits 0 -> send[2] resumes the following cycle; simultaneous send+return keeps count at 1.
- out_sw[0]=3 and out_sw[3]=3, valid[3]=1 -> only send[0]=1, en[3]=1, err_cfg=1 next cycle and stays 1.
- credit_ret[1] pulsed at full credit -> credit_cnt[1] stays 4, err_ovf=1; assert rst mid-burst -> all counters 4, flags 0 asynchronously.
- With FLOW_CTRL_STALL_CNT_EN, valid[0]=1 with credit 0 for 10 cycles -> stall_cnt[0]=10; without macro -> stall_cnt=0.
